// File: rtl/pre_adder_pkg.sv
// pre_adder_pkg: shared widths, mode encodings and stage record for the pre-adder input stage
package pre_adder_pkg;
    localparam int AY_W = 27;
    localparam int AZ_W = 26;
    localparam int BY_W = 19;
    localparam int BZ_W = 18;
    localparam int PK_W = 37;
    localparam int Y0_W = 19;
    localparam int Z0_W = 18;
    localparam logic MODE_DUAL   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;
    typedef struct packed {
        logic [AY_W-1:0] y;
        logic [AZ_W-1:0] z;
        logic [BY_W-1:0] by;
        logic [BZ_W-1:0] bz;
        logic            mode;
        logic            valid;
    } stage_t;
endpackage

// File: rtl/pre_adder_operand_reg.sv
// pre_adder_operand_reg: one operand register stage with rst/clr/ena priority
module pre_adder_operand_reg
    import pre_adder_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   ena,
    input  stage_t d,
    output stage_t q
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (ena)
            q <= d;
    end
endmodule

// File: rtl/pre_adder_input_stage.sv
// pre_adder_input_stage: registers Y/Z operands with mode and packs them into the pre-adder words
module pre_adder_input_stage
    import pre_adder_pkg::*;
#(
    parameter bit INPUT_REG_EN = 1'b1,
    parameter bit DELAY_REG_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            clr,
    input  logic            mode_in,
    input  logic            valid_in,
    input  logic            use_scanin,
    input  logic [AY_W-1:0] ay_in,
    input  logic [AZ_W-1:0] az_in,
    input  logic [BY_W-1:0] by_in,
    input  logic [BZ_W-1:0] bz_in,
    input  logic [AY_W-1:0] scanin,
    output logic [PK_W-1:0] IN1,
    output logic [PK_W-1:0] IN2,
    output logic            mode_out,
    output logic            valid_out,
    output logic [AY_W-1:0] scanout
);
    logic [AY_W-1:0] ysel;
    stage_t d, s1, s2;
    assign ysel = use_scanin ? scanin : ay_in;
    // dual mode drops the unused upper operand bits before they are registered
    assign d = '{
        y:     (mode_in == MODE_SINGLE) ? ysel : {{(AY_W-Y0_W){1'b0}}, ysel[Y0_W-1:0]},
        z:     (mode_in == MODE_SINGLE) ? az_in : {{(AZ_W-Z0_W){1'b0}}, az_in[Z0_W-1:0]},
        by:    by_in,
        bz:    bz_in,
        mode:  mode_in,
        valid: valid_in
    };
    generate
        if (INPUT_REG_EN) begin : g_s1
            pre_adder_operand_reg u_s1 (.clk(clk), .rst(rst), .clr(clr), .ena(ena), .d(d), .q(s1));
        end else begin : g_s1_wire
            assign s1 = d;
        end
        if (DELAY_REG_EN) begin : g_s2
            pre_adder_operand_reg u_s2 (.clk(clk), .rst(rst), .clr(clr), .ena(ena), .d(s1), .q(s2));
        end else begin : g_s2_wire
            assign s2 = s1;
        end
    endgenerate
    assign scanout   = s1.y;
    assign mode_out  = s2.mode;
    assign valid_out = s2.valid;
    // single mode splits Z: low 10 bits ride above Y, the rest go to IN2 in split-carry order
    assign IN1 = (s2.mode == MODE_SINGLE) ? {s2.z[9:0], s2.y} : {s2.z[Z0_W-1:0], s2.y[Y0_W-1:0]};
    assign IN2 = (s2.mode == MODE_SINGLE) ? {21'b0, s2.z[AZ_W-1:10]} : {s2.bz, s2.by};
endmodule

// File: tb/tb_pre_adder_input_stage.sv
// tb_pre_adder_input_stage: checks latency 0/1/2 variants against a beat-level reference model
module tb_pre_adder_input_stage;
    logic clk = 1'b0;
    logic rst, ena, clr, mode_in, valid_in, use_scanin;
    logic [26:0] ay_in, scanin;
    logic [25:0] az_in;
    logic [18:0] by_in;
    logic [17:0] bz_in;
    logic [36:0] in1_0, in2_0, in1_1, in2_1, in1_2, in2_2;
    logic        m0, v0, m1, v1, m2, v2;
    logic [26:0] so0, so1, so2;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [36:0] in1;
        logic [36:0] in2;
        logic        m;
        logic        v;
        logic [26:0] y;
    } exp_t;

    exp_t zero = '{in1: '0, in2: '0, m: 1'b0, v: 1'b0, y: '0};
    exp_t cur, e1, e2;

    always #5 clk = ~clk;

    pre_adder_input_stage #(.INPUT_REG_EN(1'b0), .DELAY_REG_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .mode_in(mode_in), .valid_in(valid_in),
        .use_scanin(use_scanin), .ay_in(ay_in), .az_in(az_in), .by_in(by_in), .bz_in(bz_in),
        .scanin(scanin), .IN1(in1_0), .IN2(in2_0), .mode_out(m0), .valid_out(v0), .scanout(so0));
    pre_adder_input_stage u1 (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .mode_in(mode_in), .valid_in(valid_in),
        .use_scanin(use_scanin), .ay_in(ay_in), .az_in(az_in), .by_in(by_in), .bz_in(bz_in),
        .scanin(scanin), .IN1(in1_1), .IN2(in2_1), .mode_out(m1), .valid_out(v1), .scanout(so1));
    pre_adder_input_stage #(.INPUT_REG_EN(1'b1), .DELAY_REG_EN(1'b1)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .mode_in(mode_in), .valid_in(valid_in),
        .use_scanin(use_scanin), .ay_in(ay_in), .az_in(az_in), .by_in(by_in), .bz_in(bz_in),
        .scanin(scanin), .IN1(in1_2), .IN2(in2_2), .mode_out(m2), .valid_out(v2), .scanout(so2));

    // Expected pre-adder words for one beat, built with masks and shifts from the operand rules
    function automatic exp_t ref_beat(logic m, logic v, logic us, logic [26:0] sc, logic [26:0] ay,
                                      logic [25:0] az, logic [18:0] by, logic [17:0] bz);
        exp_t r;
        logic [26:0] y;
        logic [36:0] z;
        y = us ? sc : ay;
        if (!m) y = y & 27'h007FFFF;
        z = m ? 37'(az) : 37'(az) & 37'h3FFFF;
        r.y = y;
        r.m = m;
        r.v = v;
        if (m) begin
            r.in1 = ((z % 1024) << 27) | 37'(y);
            r.in2 = z / 1024;
        end else begin
            r.in1 = (z << 19) | 37'(y);
            r.in2 = (37'(bz) << 19) | 37'(by);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic e, input logic m, input logic v,
                        input logic us, input logic [26:0] sc, input logic [26:0] ay,
                        input logic [25:0] az, input logic [18:0] by, input logic [17:0] bz);
        rst = r; clr = c; ena = e; mode_in = m; valid_in = v; use_scanin = us;
        scanin = sc; ay_in = ay; az_in = az; by_in = by; bz_in = bz;
        cur = ref_beat(m, v, us, sc, ay, az, by, bz);
        #1;
        chk("lat0_in1", in1_0, cur.in1);
        chk("lat0_in2", in2_0, cur.in2);
        chk("lat0_mode", 37'(m0), 37'(cur.m));
        chk("lat0_valid", 37'(v0), 37'(cur.v));
        chk("lat0_scan", 37'(so0), 37'(cur.y));
        @(posedge clk);
        if (r || c) begin
            e2 = zero;
            e1 = zero;
        end else if (e) begin
            e2 = e1;
            e1 = cur;
        end
        #1;
        chk("lat1_in1", in1_1, e1.in1);
        chk("lat1_in2", in2_1, e1.in2);
        chk("lat1_mode", 37'(m1), 37'(e1.m));
        chk("lat1_valid", 37'(v1), 37'(e1.v));
        chk("lat1_scan", 37'(so1), 37'(e1.y));
        chk("lat2_in1", in1_2, e2.in1);
        chk("lat2_in2", in2_2, e2.in2);
        chk("lat2_mode", 37'(m2), 37'(e2.m));
        chk("lat2_valid", 37'(v2), 37'(e2.v));
        chk("lat2_scan", 37'(so2), 37'(e1.y));
    endtask

    initial begin
        e1 = zero;
        e2 = zero;
        step(1, 0, 1, 1, 1, 0, '1, '1, '1, '1, '1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 37'(v1), 37'(0));
        chk("reset_in1", in1_2, 37'(0));
        // mode 0 basic beat
        step(0, 0, 1, 0, 1, 0, 0, 27'h0012345, 26'h002ABCD, 19'h54321, 18'h10F0F);
        chk("tp1_in1", in1_1, {18'h2ABCD, 19'h12345});
        chk("tp1_in2", in2_1, {18'h10F0F, 19'h54321});
        // mode 1 ignores by/bz
        step(0, 0, 1, 1, 1, 0, 0, 27'h5A5A5A5, 26'h3FFFFFF, '1, '1);
        chk("tp2_in1", in1_1, {10'h3FF, 27'h5A5A5A5});
        chk("tp2_in2", in2_1, 37'h0000FFFF);
        // alternating modes through the delay stage
        step(0, 0, 1, 0, 1, 0, 0, 27'h7ABCDEF, 26'h3123456, 19'h7FFFF, 18'h00001);
        step(0, 0, 1, 1, 1, 0, 0, 27'h1111111, 26'h2222222, 19'h33333, 18'h04444);
        step(0, 0, 1, 0, 0, 0, 0, 27'h0000001, 26'h0000002, 19'h00003, 18'h00004);
        // stall while inputs change
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, i[0], 1, 0, 0, 27'($urandom), 26'($urandom), 19'($urandom), 18'($urandom));
        step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // clear beats a simultaneous load, then reset mid-stream
        step(0, 1, 1, 1, 1, 0, 0, '1, '1, '1, '1);
        chk("tp5_clr_valid", 37'(v1), 37'(0));
        step(0, 0, 1, 1, 1, 0, 0, 27'h0ABCDEF, 26'h1234567, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 27'h0055555, 26'h0033333, 19'h1, 18'h2);
        chk("tp5_rst_valid2", 37'(v2), 37'(0));
        step(0, 0, 1, 0, 1, 0, 0, 27'h0000077, 26'h0000088, 19'h99, 18'hAA);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("tp5_post_rst_valid2", 37'(v2), 37'(1));
        // scan-chain cascade input
        step(0, 0, 1, 0, 1, 1, 27'h0001234, 27'h7FFFFFF, 0, 0, 0);
        chk("tp6_scanout", 37'(so1), 37'h0001234);
        step(0, 0, 1, 1, 1, 1, 27'h4000001, 27'h7FFFFFF, 0, 0, 0);
        chk("tp6_in1_y", 37'(in1_1[26:0]), 37'h4000001);
        // randomized traffic with occasional stalls, clears and resets
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), 1'($urandom), 27'($urandom), 27'($urandom),
                 26'($urandom), 19'($urandom), 18'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
